// File: rtl/com_overlay_gen_if.sv
// com_overlay_gen_if: raster, COM and sprite-BRAM signals of com_overlay_gen
// master: raster/tracker/BRAM side (drives counts, COM, rom_data_in)
// slave : overlay generator (drives rom_addr_out, crosshair_out, sprite_pixel_out, valid_out)
interface com_overlay_gen_if #(
    parameter int ADDR_W = 12
);
    logic [10:0]       hcount_in;
    logic [9:0]        vcount_in;
    logic              active_in;
    logic              new_frame_in;
    logic [10:0]       com_x_in;
    logic [9:0]        com_y_in;
    logic              com_valid_in;
    logic [ADDR_W-1:0] rom_addr_out;
    logic [23:0]       rom_data_in;
    logic              crosshair_out;
    logic [23:0]       sprite_pixel_out;
    logic              valid_out;
    modport master (
        output hcount_in, vcount_in, active_in, new_frame_in,
        output com_x_in, com_y_in, com_valid_in, rom_data_in,
        input  rom_addr_out, crosshair_out, sprite_pixel_out, valid_out
    );
    modport slave (
        input  hcount_in, vcount_in, active_in, new_frame_in,
        input  com_x_in, com_y_in, com_valid_in, rom_data_in,
        output rom_addr_out, crosshair_out, sprite_pixel_out, valid_out
    );
endinterface

// File: rtl/com_overlay_gen.sv
// com_overlay_gen: crosshair flag and sprite pixel centred on the tracked COM, LATENCY cycles behind the raster
// clk_in/rst_in: pixel clock, synchronous active-high reset
// b (slave): raster counts, COM strobe, sprite BRAM address/data, overlay outputs
module com_overlay_gen #(
    parameter int SPRITE_W = 64,
    parameter int SPRITE_H = 64,
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input logic           clk_in,
    input logic           rst_in,
    com_overlay_gen_if.slave b
);
    localparam int LATENCY = 4;
    localparam int XB = $clog2(SPRITE_W);
    localparam int YB = $clog2(SPRITE_H);
    logic [10:0]        r_pend_x, r_act_x;
    logic [9:0]         r_pend_y, r_act_y;
    logic [LATENCY-2:0] r_ins_d, r_cross_d, r_act_d;
    logic [12:0]        w_dx, w_dy;
    logic               w_ins, w_cross;
    logic [YB+XB-1:0]   w_addr;
    // Offsets from the sprite's top-left corner; 13 bits so off-screen corners go negative instead of wrapping
    assign w_dx    = {2'b0, b.hcount_in} - {2'b0, r_act_x} + 13'(SPRITE_W / 2);
    assign w_dy    = {3'b0, b.vcount_in} - {3'b0, r_act_y} + 13'(SPRITE_H / 2);
    // 0 <= offset < size exactly when every bit above the texel index is clear
    assign w_ins   = b.active_in && (w_dx[12:XB] == '0) && (w_dy[12:YB] == '0);
    assign w_cross = b.active_in && (b.hcount_in == r_act_x || b.vcount_in == r_act_y);
    assign w_addr  = {w_dy[YB-1:0], w_dx[XB-1:0]};
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pend_x           <= 11'(H_ACTIVE / 2);
            r_pend_y           <= 10'(V_ACTIVE / 2);
            r_act_x            <= 11'(H_ACTIVE / 2);
            r_act_y            <= 10'(V_ACTIVE / 2);
            r_ins_d            <= '0;
            r_cross_d          <= '0;
            r_act_d            <= '0;
            b.rom_addr_out     <= '0;
            b.sprite_pixel_out <= '0;
            b.crosshair_out    <= 1'b0;
            b.valid_out        <= 1'b0;
        end else begin
            // active_com only moves at frame start; a same-cycle strobe lands in pending for the next frame
            if (b.com_valid_in) {r_pend_x, r_pend_y} <= {b.com_x_in, b.com_y_in};
            if (b.new_frame_in) {r_act_x, r_act_y} <= {r_pend_x, r_pend_y};
            b.rom_addr_out     <= w_ins ? w_addr : '0;
            r_ins_d            <= {r_ins_d[LATENCY-3:0], w_ins};
            r_cross_d          <= {r_cross_d[LATENCY-3:0], w_cross};
            r_act_d            <= {r_act_d[LATENCY-3:0], b.active_in};
            b.sprite_pixel_out <= r_ins_d[LATENCY-2] ? b.rom_data_in : '0;
            b.crosshair_out    <= r_cross_d[LATENCY-2];
            b.valid_out        <= r_act_d[LATENCY-2];
        end
    end
endmodule

// File: tb/tb_com_overlay_gen.sv
// tb_com_overlay_gen: randomized and directed checks of com_overlay_gen against a behavioural model
module tb_com_overlay_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    com_overlay_gen_if b ();
    com_overlay_gen dut (.clk_in(clk), .rst_in(rst), .b(b));
    always #5 clk = ~clk;
    // Sprite BRAM: two-cycle read latency, texel value equals its address
    logic [11:0] bram_d1;
    always @(posedge clk) begin
        bram_d1       <= b.rom_addr_out;
        b.rom_data_in <= {12'd0, bram_d1};
    end
    typedef struct packed {
        logic        cr;
        logic [23:0] px;
        logic        vl;
        logic [11:0] ad;
    } exp_t;
    exp_t q[$];
    int pend_x, pend_y, act_x, act_y;
    int n_chk = 0, n_fail = 0;
    // Reference: per sampled pixel, what the overlay must show; q[$] is the newest sample, q[0] the one due at the outputs
    always @(posedge clk) begin : model
        exp_t e;
        int h, v;
        bit ins;
        e = '0;
        h = int'(b.hcount_in);
        v = int'(b.vcount_in);
        if (rst) begin
            foreach (q[i]) q[i] = '0;
            pend_x = 640; pend_y = 360; act_x = 640; act_y = 360;
        end else begin
            ins = b.active_in && h >= act_x - 32 && h < act_x + 32 && v >= act_y - 32 && v < act_y + 32;
            e.cr = b.active_in && (h == act_x || v == act_y);
            e.vl = b.active_in;
            if (ins) begin
                e.ad = 12'((v - (act_y - 32)) * 64 + (h - (act_x - 32)));
                e.px = 24'(e.ad);
            end
            if (b.new_frame_in) begin act_x = pend_x; act_y = pend_y; end
            if (b.com_valid_in) begin pend_x = int'(b.com_x_in); pend_y = int'(b.com_y_in); end
        end
        q.push_back(e);
        if (q.size() > 4) void'(q.pop_front());
    end
    function automatic logic [37:0] dut_o();
        return {b.crosshair_out, b.sprite_pixel_out, b.valid_out, b.rom_addr_out};
    endfunction
    function automatic logic [37:0] exp_o();
        return {q[0].cr, q[0].px, q[0].vl, q[$].ad};
    endfunction
    function automatic logic [37:0] pk(input int ad, input logic cr, input int px, input logic vl);
        return {cr, 24'(px), vl, 12'(ad)};
    endfunction
    task automatic cyc(input int h, input int v, input logic a, input logic nf = 1'b0,
                       input logic cv = 1'b0, input int cx = 0, input int cy = 0, input logic r = 1'b0);
        @(negedge clk);
        rst            = r;
        b.hcount_in    = 11'(h);
        b.vcount_in    = 10'(v);
        b.active_in    = a;
        b.new_frame_in = nf;
        b.com_valid_in = cv;
        b.com_x_in     = 11'(cx);
        b.com_y_in     = 10'(cy);
    endtask
    // One pixel, then idle: address sampled one cycle later, overlay outputs four cycles later
    task automatic probe(input int h, input int v, input logic a, output logic [37:0] o);
        logic [11:0] ad;
        cyc(h, v, a);
        cyc(0, 0, 0);
        ad = b.rom_addr_out;
        repeat (3) cyc(0, 0, 0);
        o = {b.crosshair_out, b.sprite_pixel_out, b.valid_out, ad};
    endtask
    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(640, 360, 1, 0, 0, 0, 0, 1);
            n_chk++;
            if (dut_o() !== '0) begin n_fail++; $display("FAIL reset[%0d]: got %h expected 0", i, dut_o()); end
        end
    endtask
    task automatic test_center();
        int tab[8][7] = '{'{640, 100, 1, 0, 1, 0, 1}, '{641, 100, 1, 0, 0, 0, 1},
                          '{300, 360, 1, 0, 1, 0, 1}, '{300, 361, 1, 0, 0, 0, 1},
                          '{608, 328, 1, 0, 0, 0, 1}, '{640, 360, 1, 2080, 1, 2080, 1},
                          '{1279, 719, 1, 0, 0, 0, 1}, '{640, 360, 0, 0, 0, 0, 0}};
        logic [37:0] o;
        for (int v = 359; v <= 361; v++)
            for (int h = 600; h <= 680; h++) begin
                cyc(h, v, h != 650);
                n_chk++;
                if (dut_o() !== exp_o()) begin n_fail++; $display("FAIL center_scan(%0d,%0d): got %h expected %h", h, v, dut_o(), exp_o()); end
            end
        foreach (tab[i]) begin
            probe(tab[i][0], tab[i][1], tab[i][2] != 0, o);
            n_chk++;
            if (o !== pk(tab[i][3], tab[i][4] != 0, tab[i][5], tab[i][6] != 0)) begin
                n_fail++; $display("FAIL center[%0d]: got %h expected %h", i, o, pk(tab[i][3], tab[i][4] != 0, tab[i][5], tab[i][6] != 0));
            end
        end
    endtask
    task automatic test_com_update();
        int tab[11][6] = '{'{100, 200, 0, 0, 0, 1}, '{640, 200, 0, 1, 0, 1},
                           '{100, 200, 0, 1, 0, 1}, '{640, 200, 0, 0, 0, 1},
                           '{68, 18, 0, 0, 0, 1},   '{69, 18, 1, 0, 1, 1},
                           '{131, 81, 4095, 0, 4095, 1}, '{67, 18, 0, 0, 0, 1},
                           '{132, 81, 0, 0, 0, 1},  '{68, 82, 0, 0, 0, 1},
                           '{100, 50, 2080, 1, 2080, 1}};
        logic [37:0] o;
        cyc(500, 400, 1, 0, 1, 100, 50);
        foreach (tab[i]) begin
            if (i == 2) cyc(0, 0, 0, 1);
            probe(tab[i][0], tab[i][1], 1, o);
            n_chk++;
            if (o !== pk(tab[i][2], tab[i][3] != 0, tab[i][4], tab[i][5] != 0)) begin
                n_fail++; $display("FAIL com_update[%0d]: got %h expected %h", i, o, pk(tab[i][2], tab[i][3] != 0, tab[i][4], tab[i][5] != 0));
            end
        end
    endtask
    task automatic test_edge_clip();
        int tab[9][6] = '{'{0, 0, 1750, 0, 1750, 1}, '{41, 0, 1791, 0, 1791, 1},
                          '{42, 0, 0, 0, 0, 1},      '{0, 36, 4054, 0, 4054, 1},
                          '{0, 37, 0, 0, 0, 1},      '{1279, 0, 0, 0, 0, 1},
                          '{1279, 5, 0, 1, 0, 1},    '{10, 719, 0, 1, 0, 1},
                          '{1279, 719, 0, 0, 0, 1}};
        logic [37:0] o;
        cyc(0, 0, 0, 0, 1, 10, 5);
        cyc(0, 0, 0, 1);
        foreach (tab[i]) begin
            probe(tab[i][0], tab[i][1], 1, o);
            n_chk++;
            if (o !== pk(tab[i][2], tab[i][3] != 0, tab[i][4], tab[i][5] != 0)) begin
                n_fail++; $display("FAIL edge_clip[%0d]: got %h expected %h", i, o, pk(tab[i][2], tab[i][3] != 0, tab[i][4], tab[i][5] != 0));
            end
        end
        for (int h = 1270; h < 1280; h++) begin
            cyc(h, 3, 1);
            n_chk++;
            if (dut_o() !== exp_o()) begin n_fail++; $display("FAIL edge_scan(%0d): got %h expected %h", h, dut_o(), exp_o()); end
        end
    endtask
    task automatic test_same_cycle();
        int tab[4][3] = '{'{200, 10, 1}, '{300, 10, 0}, '{300, 10, 1}, '{200, 10, 0}};
        logic [37:0] o;
        cyc(0, 0, 0, 0, 1, 200, 200);
        cyc(0, 0, 0, 1, 1, 300, 300);
        foreach (tab[i]) begin
            if (i == 2) cyc(0, 0, 0, 1);
            probe(tab[i][0], tab[i][1], 1, o);
            n_chk++;
            if (o !== pk(0, tab[i][2] != 0, 0, 1)) begin
                n_fail++; $display("FAIL same_cycle[%0d]: got %h expected %h", i, o, pk(0, tab[i][2] != 0, 0, 1));
            end
        end
    endtask
    task automatic test_offscreen();
        int tab[3][3] = '{'{1279, 100, 0}, '{100, 400, 1}, '{1279, 400, 1}};
        logic [37:0] o;
        cyc(0, 0, 0, 0, 1, 1500, 400);
        cyc(0, 0, 0, 1);
        foreach (tab[i]) begin
            probe(tab[i][0], tab[i][1], 1, o);
            n_chk++;
            if (o !== pk(0, tab[i][2] != 0, 0, 1)) begin
                n_fail++; $display("FAIL offscreen[%0d]: got %h expected %h", i, o, pk(0, tab[i][2] != 0, 0, 1));
            end
        end
    endtask
    task automatic test_mid_reset();
        cyc(0, 0, 0, 0, 1, 100, 50);
        cyc(0, 0, 0, 1);
        repeat (5) cyc(100, 50, 1);
        n_chk++;
        if (dut_o() !== pk(2080, 1, 2080, 1)) begin n_fail++; $display("FAIL pre_reset: got %h expected %h", dut_o(), pk(2080, 1, 2080, 1)); end
        cyc(100, 50, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(640, 50, 1);
            n_chk++;
            if (dut_o() !== pk(0, i == 4, 0, i == 4)) begin
                n_fail++; $display("FAIL mid_reset[%0d]: got %h expected %h", i, dut_o(), pk(0, i == 4, 0, i == 4));
            end
        end
    endtask
    task automatic test_random();
        int h, v;
        for (int i = 0; i < 4000; i++) begin
            h = ($urandom % 4 == 0) ? int'($urandom % 2048) : act_x - 40 + int'($urandom % 81);
            v = ($urandom % 4 == 0) ? int'($urandom % 1024) : act_y - 40 + int'($urandom % 81);
            h = h < 0 ? 0 : (h > 2047 ? 2047 : h);
            v = v < 0 ? 0 : (v > 1023 ? 1023 : v);
            cyc(h, v, $urandom % 8 != 0, $urandom % 50 == 0, $urandom % 40 == 0,
                int'($urandom % 1400), int'($urandom % 760), $urandom % 500 == 0);
            n_chk++;
            if (dut_o() !== exp_o()) begin n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, dut_o(), exp_o()); end
        end
    endtask
    initial begin
        repeat (4) q.push_back('0);
        b.hcount_in = '0; b.vcount_in = '0; b.active_in = 1'b0; b.new_frame_in = 1'b0;
        b.com_x_in = '0; b.com_y_in = '0; b.com_valid_in = 1'b0;
        test_reset();
        test_center();
        test_com_update();
        test_edge_clip();
        test_same_cycle();
        test_offscreen();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
